// File: rtl/rpi_irq_pkg.sv
// Shared definitions for the Raspberry Pi interrupt handshake logic.
package rpi_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_ASSERT       = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } irq_state_e;

  // 1.333 ms at 50 MHz.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 66666;

endpackage

// File: rtl/rpi_sync2.sv
// Two-flop synchronizer for asynchronous Pi GPIO inputs.
module rpi_sync2 (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // Double-register the asynchronous input into the clk_in domain.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/rpi_irq_handshake.sv
// Responder end of the FPGA-to-Pi interrupt link: raises irq_out on a period
// tick, drops it on acknowledge or timeout, and counts missed interrupts.
module rpi_irq_handshake
  import rpi_irq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned MISS_W         = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              irq_enable,
  input  logic              rpi_ack,
  input  logic              miss_clear,
  output logic              irq_out,
  output logic              ack_pulse,
  output logic              timeout_pulse,
  output logic              busy,
  output logic [MISS_W-1:0] miss_count
);

  localparam int unsigned       TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [MISS_W:0]   MISS_MAX   = {1'b0, {MISS_W{1'b1}}};

  irq_state_e         state;
  irq_state_e         state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               irq_nxt;
  logic               ack_nxt;
  logic               to_nxt;
  logic [MISS_W-1:0]  miss_nxt;

  logic               ack_s2;
  logic               ack_s3;
  logic               ack_rise;
  logic               ack_lvl;
  logic               overrun;
  logic [1:0]         miss_inc;
  logic [MISS_W:0]    miss_base;
  logic [MISS_W:0]    miss_sum;

  rpi_sync2 u_ack_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (rpi_ack),
    .q      (ack_s2)
  );

  // History flop for rising-edge detection on the synchronized acknowledge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ack_s3 <= 1'b0;
    end else begin
      ack_s3 <= ack_s2;
    end
  end

  assign ack_rise = ack_s2 & ~ack_s3;
  assign ack_lvl  = ack_s2;
  assign busy     = (state != ST_IDLE);
  assign overrun  = tick & busy;

  // Next-state, timer, pulse and miss-counter logic.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    ack_nxt   = 1'b0;
    to_nxt    = 1'b0;
    irq_nxt   = 1'b0;
    miss_inc  = 2'd0;
    miss_base = '0;
    miss_sum  = '0;
    miss_nxt  = miss_count;

    case (state)
      ST_IDLE: begin
        if (tick && irq_enable) begin
          state_nxt = ST_ASSERT;
          timer_nxt = '0;
        end
      end
      ST_ASSERT: begin
        if (!irq_enable) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (ack_rise) begin
          state_nxt = ST_WAIT_RELEASE;
          ack_nxt   = 1'b1;
          timer_nxt = '0;
        end else if (timer == TIMER_LAST) begin
          state_nxt = ST_WAIT_RELEASE;
          to_nxt    = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      ST_WAIT_RELEASE: begin
        if (!ack_lvl) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase

    irq_nxt = (state_nxt == ST_ASSERT);

    // Clear is applied before this cycle's increments; sum is one bit wider
    // so saturation can be detected for a +2 step.
    miss_inc  = {1'b0, to_nxt} + {1'b0, overrun};
    miss_base = miss_clear ? '0 : {1'b0, miss_count};
    miss_sum  = miss_base + (MISS_W+1)'(miss_inc);
    miss_nxt  = (miss_sum > MISS_MAX) ? MISS_MAX[MISS_W-1:0] : miss_sum[MISS_W-1:0];
  end

  // State, timer, registered outputs and miss counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      irq_out       <= 1'b0;
      ack_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      miss_count    <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      irq_out       <= irq_nxt;
      ack_pulse     <= ack_nxt;
      timeout_pulse <= to_nxt;
      miss_count    <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_rpi_irq_handshake.sv
// Directed self-checking bench for rpi_irq_handshake (TIMEOUT_CYCLES=16).
module tb_rpi_irq_handshake;

  logic       clk_in;
  logic       rst_n;
  logic       tick;
  logic       irq_enable;
  logic       rpi_ack;
  logic       miss_clear;
  logic       irq_out;
  logic       ack_pulse;
  logic       timeout_pulse;
  logic       busy;
  logic [7:0] miss_count;

  int n_checks = 0;
  int n_err    = 0;

  rpi_irq_handshake #(
    .TIMEOUT_CYCLES (16),
    .MISS_W         (8)
  ) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .tick          (tick),
    .irq_enable    (irq_enable),
    .rpi_ack       (rpi_ack),
    .miss_clear    (miss_clear),
    .irq_out       (irq_out),
    .ack_pulse     (ack_pulse),
    .timeout_pulse (timeout_pulse),
    .busy          (busy),
    .miss_count    (miss_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hi_cnt;
    int both_hi;

    rst_n      = 1'b0;
    tick       = 1'b0;
    irq_enable = 1'b1;
    rpi_ack    = 1'b0;
    miss_clear = 1'b0;

    // Reset state
    #12;
    check("rst_irq", irq_out, 0);
    check("rst_ack", ack_pulse, 0);
    check("rst_to", timeout_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_miss", miss_count, 0);
    step();
    rst_n = 1'b1;
    step();

    // Reset mid-ASSERT
    tick = 1'b1; step(); tick = 1'b0;
    check("mid_irq_up", irq_out, 1);
    steps(10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_irq", irq_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_miss", miss_count, 0);
    step();
    rst_n = 1'b1;
    step();
    tick = 1'b1; step(); tick = 1'b0;
    check("post_rst_irq", irq_out, 1);
    irq_enable = 1'b0; step(); irq_enable = 1'b1;
    check("post_rst_abort", busy, 0);

    // Normal handshake
    tick = 1'b1; step(); tick = 1'b0;
    check("hs_irq_up", irq_out, 1);
    steps(9);
    rpi_ack = 1'b1;
    step();                         // first sample edge k
    step();                         // k+1
    check("hs_irq_k1", irq_out, 1);
    check("hs_ackp_k1", ack_pulse, 0);
    step();                         // k+2
    check("hs_irq_k2", irq_out, 0);
    check("hs_ackp_k2", ack_pulse, 1);
    check("hs_to_k2", timeout_pulse, 0);
    step();
    check("hs_ackp_once", ack_pulse, 0);
    check("hs_busy_held", busy, 1);
    rpi_ack = 1'b0;
    steps(3);
    check("hs_busy_rel", busy, 0);
    check("hs_miss", miss_count, 0);

    // Timeout: irq_out high exactly 16 cycles
    tick = 1'b1; step(); tick = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (irq_out === 1'b1 && timeout_pulse === 1'b0) hi_cnt++;
      step();
    end
    if (irq_out === 1'b1 && timeout_pulse === 1'b0) hi_cnt++;
    check("to_hi_cycles", hi_cnt, 16);
    step();
    check("to_irq_fall", irq_out, 0);
    check("to_pulse", timeout_pulse, 1);
    check("to_miss", miss_count, 1);
    step();
    check("to_pulse_once", timeout_pulse, 0);
    step();
    check("to_busy_rel", busy, 0);

    // miss_clear
    miss_clear = 1'b1; step(); miss_clear = 1'b0;
    check("clr_miss", miss_count, 0);

    // Overrun tick 5 cycles after the first
    tick = 1'b1; step(); tick = 1'b0;
    steps(4);
    tick = 1'b1; step(); tick = 1'b0;
    check("ovr_miss1", miss_count, 1);
    steps(10);
    check("ovr_irq_held", irq_out, 1);
    check("ovr_miss_held", miss_count, 1);
    step();
    check("ovr_to", timeout_pulse, 1);
    check("ovr_miss2", miss_count, 2);
    steps(2);

    // Overrun tick on the timeout cycle: +2
    miss_clear = 1'b1; step(); miss_clear = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    steps(15);
    check("dbl_irq_held", irq_out, 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("dbl_to", timeout_pulse, 1);
    check("dbl_miss", miss_count, 2);
    steps(2);
    check("dbl_busy_rel", busy, 0);

    // Drop irq_enable mid-ASSERT
    tick = 1'b1; step(); tick = 1'b0;
    steps(3);
    irq_enable = 1'b0; step();
    check("ab_irq", irq_out, 0);
    check("ab_ackp", ack_pulse, 0);
    check("ab_to", timeout_pulse, 0);
    check("ab_busy", busy, 0);
    check("ab_miss", miss_count, 2);
    // tick while disabled in IDLE is ignored
    tick = 1'b1; step(); tick = 1'b0;
    check("dis_irq", irq_out, 0);
    check("dis_busy", busy, 0);
    check("dis_miss", miss_count, 2);
    irq_enable = 1'b1;
    step();

    // miss_clear coincident with timeout
    tick = 1'b1; step(); tick = 1'b0;
    steps(15);
    miss_clear = 1'b1; step(); miss_clear = 1'b0;
    check("clrto_pulse", timeout_pulse, 1);
    check("clrto_miss", miss_count, 1);
    steps(2);

    // ack_rise on the timer==15 cycle: ack wins
    tick = 1'b1; step(); tick = 1'b0;
    steps(13);
    rpi_ack = 1'b1;
    step();
    step();
    check("race_irq_held", irq_out, 1);
    step();
    check("race_ackp", ack_pulse, 1);
    check("race_to", timeout_pulse, 0);
    check("race_irq", irq_out, 0);
    check("race_miss", miss_count, 1);
    rpi_ack = 1'b0;
    steps(4);
    check("race_busy_rel", busy, 0);

    // rpi_ack stuck high across the tick
    rpi_ack = 1'b1;
    steps(3);
    tick = 1'b1; step(); tick = 1'b0;
    check("stuck_irq_up", irq_out, 1);
    steps(15);
    step();
    check("stuck_to", timeout_pulse, 1);
    check("stuck_ackp", ack_pulse, 0);
    check("stuck_miss", miss_count, 2);
    steps(5);
    check("stuck_busy", busy, 1);
    check("stuck_irq_low", irq_out, 0);
    rpi_ack = 1'b0;
    steps(3);
    check("stuck_busy_rel", busy, 0);

    // Saturation over 300 timeouts
    miss_clear = 1'b1; step(); miss_clear = 1'b0;
    both_hi = 0;
    for (int n = 1; n <= 300; n++) begin
      tick = 1'b1; step(); tick = 1'b0;
      for (int i = 0; i < 18; i++) begin
        if (ack_pulse === 1'b1 && timeout_pulse === 1'b1) both_hi++;
        step();
      end
      if (n == 100) check("sat_miss100", miss_count, 100);
    end
    check("sat_miss", miss_count, 255);
    check("sat_exclusive", both_hi, 0);
    tick = 1'b1; step(); tick = 1'b0;
    steps(2);
    tick = 1'b1; step(); tick = 1'b0;
    check("sat_ovr_hold", miss_count, 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
